// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier: one recoded digit per RUN cycle into a
// 2N+2-bit accumulator, exact 2N-bit signed/unsigned product on a
// valid/ready handshake.
// Optional build macro: BOOTH_EARLY_TERM_EN (leave RUN once the remaining
// multiplier digits are all zero).
module booth_r4_seq_mul #(
    parameter int unsigned N = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N-1:0]   mulcand_i,
    input  logic [N-1:0]   mulplier_i,
    input  logic           sign_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*N-1:0] product_o,
    output logic           busy_o
);

    localparam int unsigned Iter = N / 2 + 1;
    localparam int unsigned AccW = 2 * N + 2;
    localparam int unsigned EW   = N + 3;
    localparam int unsigned CntW = $clog2(Iter);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      m_q, m_d;
    logic [EW-1:0]     e_q, e_d;
    logic              sign_q, sign_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AccW-1:0]   acc_q, acc_d;

    logic [2:0]        trip;
    logic              neg;
    logic [N:0]        raw;
    logic [N+1:0]      pp;
    logic [AccW-1:0]   addend;
    logic              last_digit;

    // e_q is shifted right two bits per digit, so the current triplet is
    // always the bottom three bits.
    assign trip = e_q[2:0];
    assign neg  = trip[2];

    // Select the raw magnitude (0, M or 2M) for the current triplet.
    always_comb begin
        raw = '0;
        unique case (trip)
            3'b001, 3'b010, 3'b101, 3'b110: raw = {sign_q & m_q[N-1], m_q};
            3'b011, 3'b100:                 raw = {m_q, 1'b0};
            default:                        raw = '0;
        endcase
    end

    // Top bit is the raw value's own sign (zero when unsigned), flipped on
    // negation; the +1 of the two's-complement negate rides in addend.
    assign pp     = {(sign_q & raw[N]) ^ neg, raw ^ {(N + 1){neg}}};
    assign addend = ({{(AccW - N - 2){pp[N+1]}}, pp} + AccW'(neg)) << {cnt_q, 1'b0};

`ifdef BOOTH_EARLY_TERM_EN
    logic [EW-3:0] rest;
    // The arithmetic shift keeps the fill equal to the top bit, so uniform
    // remaining bits mean every later triplet is 000 or 111.
    assign rest       = e_q[EW-1:2];
    assign last_digit = (cnt_q == CntW'(Iter - 1)) || (rest == '0) || (&rest);
`else
    assign last_digit = (cnt_q == CntW'(Iter - 1));
`endif

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        e_d         = e_q;
        sign_d      = sign_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    m_d     = mulcand_i;
                    sign_d  = sign_i;
                    e_d     = {{2{sign_i & mulplier_i[N-1]}}, mulplier_i, 1'b0};
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy_o = 1'b1;
                acc_d  = acc_q + addend;
                e_d    = {{2{e_q[EW-1]}}, e_q[EW-1:2]};
                cnt_d  = cnt_q + CntW'(1);
                if (last_digit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign product_o = acc_q[2*N-1:0];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            m_q     <= '0;
            e_q     <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed bench for booth_r4_seq_mul (N=32), plus a short random sweep
// against a behavioural multiply.
module tb_booth_r4_seq_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] mulcand = '0;
    logic [31:0] mulplier = '0;
    logic        sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] product;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_r4_seq_mul #(.N(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mulcand_i   (mulcand),
        .mulplier_i  (mulplier),
        .sign_i      (sign),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .product_o   (product),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected accept-to-out_valid latency: et_lat with early termination, else 18.
    function automatic int lat_of(input int et_lat);
`ifdef BOOTH_EARLY_TERM_EN
        return et_lat;
`else
        return 18 + 0 * et_lat;
`endif
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q,
                                            input logic s);
        logic signed [63:0] a;
        logic signed [63:0] b;
        if (s) begin
            a = {{32{m[31]}}, m};
            b = {{32{q[31]}}, q};
            return a * b;
        end
        return {32'b0, m} * {32'b0, q};
    endfunction

    // Highest non-zero Booth digit decides the early-termination latency.
    function automatic int model_lat(input logic [31:0] q, input logic s);
        logic [34:0] e;
        logic [2:0]  t;
        int          hi;
        e  = {s & q[31], s & q[31], q, 1'b0};
        hi = 0;
        for (int i = 0; i < 17; i++) begin
            t = e[2*i +: 3];
            if (t != 3'b000 && t != 3'b111) hi = i;
        end
        return lat_of(hi + 2);
    endfunction

    // Called just after a negedge; returns just after the accepting posedge.
    task automatic start_op(input logic [31:0] m, input logic [31:0] q, input logic s);
        int k = 0;
        mulcand  = m;
        mulplier = q;
        sign     = s;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts negedges until out_valid; busy must be the complement of out_valid.
    task automatic wait_result(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (busy !== !out_valid) busy_ok = 1'b0;
        end while (out_valid !== 1'b1 && lat < 40);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                          input logic s, input logic [63:0] exp, input int exp_lat);
        int   lat;
        logic bok;
        start_op(m, q, s);
        wait_result(lat, bok);
        check({tag, "_product"}, product, exp);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, {63'b0, bok}, 64'd1);
        take();
    endtask

    initial begin
        int          lat;
        logic        bok;
        logic        bp_ok;
        logic [31:0] m;
        logic [31:0] q;
        logic        s;

        // Reset values
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);

        // Directed products
        run_op("u_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 18);
        run_op("s_maxpos", 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001, lat_of(17));
        run_op("s_minmax", 32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000, lat_of(17));
        run_op("u_shift", 32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000, lat_of(3));
        run_op("s_neg2neg3", 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 64'd6, lat_of(3));
        run_op("u_big", 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 64'hFFFFFFFB00000006, 18);
        run_op("q_zero", 32'h00001234, 32'h00000000, 1'b0, 64'd0, lat_of(2));
        run_op("q_one", 32'hDEADBEEF, 32'h00000001, 1'b1, 64'hFFFFFFFFDEADBEEF, lat_of(2));

        // Most-negative squared, then 10 cycles of backpressure in DONE
        start_op(32'h80000000, 32'h80000000, 1'b1);
        wait_result(lat, bok);
        check("s_minsq_product", product, 64'h4000000000000000);
        check("s_minsq_latency", 64'(lat), 64'(lat_of(17)));
        bp_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (product !== 64'h4000000000000000 || out_valid !== 1'b1 || in_ready !== 1'b0)
                bp_ok = 1'b0;
        end
        check("backpressure_hold", {63'b0, bp_ok}, 64'd1);

        // Result taken with a new operand already offered: not accepted this edge
        mulcand   = 32'hFFFFFFFF;
        mulplier  = 32'h00000007;
        sign      = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("take_in_ready", {63'b0, in_ready}, 64'd1);
        check("take_out_valid", {63'b0, out_valid}, 64'd0);
        check("take_busy", {63'b0, busy}, 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(lat, bok);
        check("b2b_product", product, 64'hFFFFFFFFFFFFFFF9);
        check("b2b_latency", 64'(lat), 64'(lat_of(3)));
        take();

        // Reset while processing digit 5
        start_op(32'h12345678, 32'h40000009, 1'b1);
        repeat (6) @(negedge clk);
        check("midrun_busy", {63'b0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", {63'b0, in_ready}, 64'd1);
        check("abort_out_valid", {63'b0, out_valid}, 64'd0);
        check("abort_product", product, 64'd0);
        check("abort_busy", {63'b0, busy}, 64'd0);
        run_op("after_abort", 32'd3, 32'd5, 1'b0, 64'd15, lat_of(3));

        // Random signed and unsigned pairs
        for (int i = 0; i < 300; i++) begin
            m = $urandom;
            q = $urandom;
            s = 1'($urandom_range(0, 1));
            run_op("rand", m, q, s, ref_mul(m, q, s), model_lat(q, s));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
